// File: rtl/iram_loader_if.sv
// Stream-in and IRAM-write signal bundle for iram_loader.
// master = boot-side source and IRAM sink; slave = the loader itself.
interface iram_loader_if #(
  parameter int unsigned LEN_W = 16
);
  logic             START;
  logic [LEN_W-1:0] LEN;
  logic             S_VALID;
  logic [7:0]       S_DATA;
  logic             S_READY;
  logic             HWRITE;
  logic [63:0]      HADDR;
  logic [63:0]      HWDATA;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  modport master (
    output START, LEN, S_VALID, S_DATA,
    input  S_READY, HWRITE, HADDR, HWDATA, BUSY, DONE, ERR
  );

  modport slave (
    input  START, LEN, S_VALID, S_DATA,
    output S_READY, HWRITE, HADDR, HWDATA, BUSY, DONE, ERR
  );
endinterface

// File: rtl/iram_loader.sv
// Boot-time byte-stream loader: packs bytes little-endian into 64-bit IRAM writes.
// Optional trailer checksum check enabled by defining IRAM_LOADER_CKSUM_EN.
module iram_loader #(
  parameter logic [63:0] RAM_START = 64'h0000_0000_0002_0000,
  parameter int unsigned RAM_SIZE  = 1072,
  parameter int unsigned LEN_W     = 16
) (
  input logic         CLK,
  input logic         HRESET,
  iram_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_FIN     = 3'd3
`ifdef IRAM_LOADER_CKSUM_EN
    , S_CKSUM = 3'd4
`endif
  } state_t;

  state_t           r_state;
  logic             r_s_ready;
  logic             r_hwrite;
  logic [63:0]      r_haddr;
  logic [63:0]      r_hwdata;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [63:0]      r_pack;
  logic [2:0]       r_lane;
  logic [LEN_W-1:0] r_rem;
  logic [63:0]      r_off;
`ifdef IRAM_LOADER_CKSUM_EN
  logic [7:0]       r_sum;
`endif

  logic        w_accept;
  logic        w_len_zero;
  logic        w_len_big;
  logic        w_word_end;
  logic [63:0] w_pack;

  assign w_accept   = bus.S_VALID & r_s_ready;
  assign w_len_zero = (bus.LEN == {LEN_W{1'b0}});
  assign w_len_big  = (32'(bus.LEN) > 32'(RAM_SIZE));
  assign w_word_end = (r_lane == 3'd7) || (r_rem == LEN_W'(1));
  // Incoming byte merged into its lane; lanes above stay zero for a short final word.
  assign w_pack     = r_pack | ({56'd0, bus.S_DATA} << {r_lane, 3'b000});

  assign bus.S_READY = r_s_ready;
  assign bus.HWRITE  = r_hwrite;
  assign bus.HADDR   = r_haddr;
  assign bus.HWDATA  = r_hwdata;
  assign bus.BUSY    = r_busy;
  assign bus.DONE    = r_done;
  assign bus.ERR     = r_err;

  // Load sequencer: state, counters, pack register and all registered outputs.
  always_ff @(posedge CLK or negedge HRESET) begin
    if (!HRESET) begin
      r_state   <= S_IDLE;
      r_s_ready <= 1'b0;
      r_hwrite  <= 1'b0;
      r_haddr   <= 64'd0;
      r_hwdata  <= 64'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_pack    <= 64'd0;
      r_lane    <= 3'd0;
      r_rem     <= {LEN_W{1'b0}};
      r_off     <= 64'd0;
`ifdef IRAM_LOADER_CKSUM_EN
      r_sum     <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (bus.START) begin
            if (w_len_big) begin
              r_state   <= S_FIN;
              r_done    <= 1'b1;
              r_err     <= 1'b1;
              r_busy    <= 1'b0;
              r_s_ready <= 1'b0;
            end else if (w_len_zero) begin
`ifdef IRAM_LOADER_CKSUM_EN
              // Even an empty load is followed by a trailer byte (expected sum 0).
              r_state   <= S_CKSUM;
              r_s_ready <= 1'b1;
              r_busy    <= 1'b1;
              r_done    <= 1'b0;
              r_err     <= 1'b0;
              r_sum     <= 8'd0;
`else
              r_state   <= S_FIN;
              r_s_ready <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_err     <= 1'b0;
`endif
            end else begin
              r_state   <= S_COLLECT;
              r_s_ready <= 1'b1;
              r_busy    <= 1'b1;
              r_done    <= 1'b0;
              r_err     <= 1'b0;
              r_off     <= 64'd0;
              r_lane    <= 3'd0;
              r_pack    <= 64'd0;
              r_rem     <= bus.LEN;
`ifdef IRAM_LOADER_CKSUM_EN
              r_sum     <= 8'd0;
`endif
            end
          end else begin
            r_state <= r_state;
          end
        end

        S_COLLECT: begin
          if (w_accept) begin
            r_rem  <= r_rem - LEN_W'(1);
            r_lane <= r_lane + 3'd1;
            r_pack <= w_pack;
`ifdef IRAM_LOADER_CKSUM_EN
            r_sum  <= r_sum + bus.S_DATA;
`endif
            if (w_word_end) begin
              r_state   <= S_WRITE;
              r_s_ready <= 1'b0;
              r_hwrite  <= 1'b1;
              r_haddr   <= RAM_START + r_off;
              r_hwdata  <= w_pack;
            end else begin
              r_state <= S_COLLECT;
            end
          end else begin
            r_state <= S_COLLECT;
          end
        end

        S_WRITE: begin
          r_hwrite <= 1'b0;
          r_haddr  <= 64'd0;
          r_hwdata <= 64'd0;
          r_off    <= r_off + 64'd8;
          r_lane   <= 3'd0;
          r_pack   <= 64'd0;
          if (r_rem != {LEN_W{1'b0}}) begin
            r_state   <= S_COLLECT;
            r_s_ready <= 1'b1;
          end else begin
`ifdef IRAM_LOADER_CKSUM_EN
            r_state   <= S_CKSUM;
            r_s_ready <= 1'b1;
`else
            r_state   <= S_FIN;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
`endif
          end
        end

`ifdef IRAM_LOADER_CKSUM_EN
        S_CKSUM: begin
          if (w_accept) begin
            r_err     <= (bus.S_DATA != r_sum);
            r_state   <= S_FIN;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_state <= S_CKSUM;
          end
        end
`endif

        default: begin
          r_state   <= S_IDLE;
          r_s_ready <= 1'b0;
          r_hwrite  <= 1'b0;
          r_haddr   <= 64'd0;
          r_hwdata  <= 64'd0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader with a write scoreboard and an IRAM image model.
module tb_iram_loader;
  localparam logic [63:0] RAM_START = 64'h0000_0000_0002_0000;
  localparam int          NWORDS    = 134;

  logic clk    = 1'b0;
  logic hreset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_writes = 0;
  logic idle_bad = 1'b0;
  logic [63:0]  last_addr = 64'd0;
  logic [127:0] sb[$];
  logic [63:0]  iram [NWORDS];

  iram_loader_if #(.LEN_W(16)) bus ();

  iram_loader #(
    .RAM_START(RAM_START),
    .RAM_SIZE (1072),
    .LEN_W    (16)
  ) u_dut (
    .CLK   (clk),
    .HRESET(hreset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Write monitor: pops the scoreboard and records into the IRAM image.
  always @(negedge clk) begin
    if (hreset) begin
      if (bus.HWRITE === 1'b1) begin
        logic [127:0] e;
        int idx;
        n_writes  = n_writes + 1;
        last_addr = bus.HADDR;
        if (sb.size() == 0) begin
          chk("unexpected_write", bus.HADDR, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("haddr", bus.HADDR, e[127:64]);
          chk("hwdata", bus.HWDATA, e[63:0]);
        end
        idx = int'((bus.HADDR - RAM_START) >> 3);
        if (idx >= 0 && idx < NWORDS) iram[idx] = bus.HWDATA;
      end else if (bus.HADDR !== 64'd0 || bus.HWDATA !== 64'd0) begin
        idle_bad = 1'b1;
      end
    end
  end

  task automatic pulse_start(input int len);
    bus.START = 1'b1;
    bus.LEN   = 16'(len);
    @(posedge clk); #1;
    bus.START = 1'b0;
    bus.LEN   = 16'd0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    bus.S_VALID = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.S_VALID = 1'b1;
    bus.S_DATA  = b;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (bus.S_READY === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.S_VALID = 1'b0;
    if (!ok) chk("s_ready_timeout", 64'd0, 64'd1);
  endtask

  // One full load with its own packing model; inj >= 0 pulses START before byte inj.
  task automatic send_load(input int len, input logic [7:0] first, input int maxgap,
                           input int inj, input logic bad_trailer);
    logic [63:0] pack = 64'd0;
    logic [63:0] off  = 64'd0;
    logic [7:0]  sum  = 8'd0;
    logic [7:0]  b;
    int lane = 0;
    pulse_start(len);
    for (int i = 0; i < len; i++) begin
      if (i == inj) begin
        pulse_start(0);
        @(negedge clk);
        chk("busy_after_ignored_start", 64'(bus.BUSY), 64'd1);
        chk("done_after_ignored_start", 64'(bus.DONE), 64'd0);
        @(posedge clk); #1;
      end
      b = 8'(int'(first) + i);
      send_byte(b, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      pack[lane*8 +: 8] = b;
      sum  = sum + b;
      lane = lane + 1;
      if (lane == 8 || i == len - 1) begin
        sb.push_back({RAM_START + off, pack});
        off  = off + 64'd8;
        pack = 64'd0;
        lane = 0;
      end
    end
`ifdef IRAM_LOADER_CKSUM_EN
    send_byte(bad_trailer ? sum + 8'd1 : sum, 0);
`else
    if (bad_trailer) chk("trailer_unsupported", 64'd0, 64'd1);
`endif
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) break;
    end
    chk(tag, 64'(bus.DONE), 64'd1);
  endtask

  initial begin
    int w0;
    logic [63:0] w;
    bus.START = 1'b0; bus.LEN = 16'd0; bus.S_VALID = 1'b0; bus.S_DATA = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {bus.S_READY, bus.HWRITE, bus.BUSY, bus.DONE, bus.ERR}, 64'd0);
    chk("rst_haddr", bus.HADDR, 64'd0);
    @(posedge clk); #1;
    hreset = 1'b1;
    @(posedge clk); #1;

    // T1: one full word, exact write and DONE timing
    send_load(8, 8'h01, 0, -1, 1'b0);
`ifndef IRAM_LOADER_CKSUM_EN
    @(negedge clk);
    chk("t1_hwrite", 64'(bus.HWRITE), 64'd1);
    chk("t1_done_during_write", 64'(bus.DONE), 64'd0);
    @(negedge clk);
    chk("t1_done", 64'(bus.DONE), 64'd1);
    chk("t1_busy", 64'(bus.BUSY), 64'd0);
`endif
    wait_done("t1_wait_done");
    chk("t1_err", 64'(bus.ERR), 64'd0);
    chk("t1_writes", 64'(n_writes), 64'd1);

    // T2: partial final word with random stream gaps
    @(posedge clk); #1;
    send_load(11, 8'h01, 3, -1, 1'b0);
    wait_done("t2_done");
    chk("t2_writes", 64'(n_writes), 64'd3);
    chk("t2_last_addr", last_addr, 64'h0000_0000_0002_0008);

    // T3: full IRAM, then read back the image
    @(posedge clk); #1;
    w0 = n_writes;
    send_load(1072, 8'h00, 0, -1, 1'b0);
    wait_done("t3_done");
    chk("t3_writes", 64'(n_writes - w0), 64'(NWORDS));
    chk("t3_last_addr", last_addr, 64'h0000_0000_0002_0428);
    chk("t3_err", 64'(bus.ERR), 64'd0);
    for (int k = 0; k < NWORDS; k++) begin
      for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(8*k + j);
      chk("t3_readback", iram[k], w);
    end

    // T4: LEN=0, LEN too large, START while busy
    @(posedge clk); #1;
    w0 = n_writes;
    pulse_start(0);
`ifdef IRAM_LOADER_CKSUM_EN
    send_byte(8'h00, 0);
    wait_done("t4_len0_done");
`else
    @(negedge clk);
    chk("t4_len0_done", 64'(bus.DONE), 64'd1);
    chk("t4_len0_busy", 64'(bus.BUSY), 64'd0);
`endif
    chk("t4_len0_err", 64'(bus.ERR), 64'd0);
    @(posedge clk); #1;
    pulse_start(1073);
    @(negedge clk);
    chk("t4_big_done", 64'(bus.DONE), 64'd1);
    chk("t4_big_err", 64'(bus.ERR), 64'd1);
    chk("t4_big_busy", 64'(bus.BUSY), 64'd0);
    repeat (3) @(negedge clk);
    chk("t4_no_writes", 64'(n_writes - w0), 64'd0);
    @(posedge clk); #1;
    send_load(8, 8'h11, 0, 3, 1'b0);
    wait_done("t4_busy_done");
    chk("t4_busy_err", 64'(bus.ERR), 64'd0);
    chk("t4_busy_writes", 64'(n_writes - w0), 64'd1);

    // T5: asynchronous reset mid-load, then a fresh load from the base address
    @(posedge clk); #1;
    pulse_start(16);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 0);
    #2;
    hreset = 1'b0;
    #1;
    chk("t5_rst_flags", {bus.S_READY, bus.HWRITE, bus.BUSY, bus.DONE, bus.ERR}, 64'd0);
    chk("t5_rst_haddr", bus.HADDR, 64'd0);
    chk("t5_rst_hwdata", bus.HWDATA, 64'd0);
    @(posedge clk); #1;
    hreset = 1'b1;
    @(posedge clk); #1;
    w0 = n_writes;
    send_load(8, 8'h01, 0, -1, 1'b0);
    wait_done("t5_done");
    chk("t5_writes", 64'(n_writes - w0), 64'd1);
    chk("t5_addr", last_addr, RAM_START);

`ifdef IRAM_LOADER_CKSUM_EN
    // T6: good and bad trailer
    @(posedge clk); #1;
    send_load(8, 8'h01, 0, -1, 1'b0);
    wait_done("t6_good_done");
    chk("t6_good_err", 64'(bus.ERR), 64'd0);
    @(posedge clk); #1;
    w0 = n_writes;
    send_load(8, 8'h01, 0, -1, 1'b1);
    wait_done("t6_bad_done");
    chk("t6_bad_err", 64'(bus.ERR), 64'd1);
    chk("t6_bad_written", 64'(n_writes - w0), 64'd1);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("idle_bus_zero", 64'(idle_bad), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
